target_arbiter: RTL



---
 rtl/target_arbiter_pkg.sv | 12 +
 rtl/target_arbiter_if.sv | 29 ++
 rtl/target_arbiter_rr_select.sv | 35 +++
 rtl/target_arbiter.sv | 83 ++++++++
 4 files changed

// File: rtl/target_arbiter_pkg.sv
// Shared constants and helpers for the target-side crossbar arbiter.
// Index width rule: one bit minimum, so NumIn == 1 still has a 1-bit index.
package target_arbiter_pkg;

    localparam int DefNumIn     = 32;
    localparam int DefDataWidth = 32;

    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/target_arbiter_if.sv
// Bundle of the initiator-side request vectors and the target-side
// registered request. The arbiter uses the slave view.
interface target_arbiter_if
    import target_arbiter_pkg::*;
#(
    parameter int NumIn     = DefNumIn,
    parameter int DataWidth = DefDataWidth
);
    localparam int NumInLog = idx_width(NumIn);

    logic [NumIn-1:0]                valid_i;
    logic [NumIn-1:0]                ready_o;
    logic [NumIn-1:0][DataWidth-1:0] data_i;
    logic                            valid_o;
    logic                            ready_i;
    logic [DataWidth-1:0]            data_o;
    logic [NumInLog-1:0]             idx_o;

    modport slave (
        input  valid_i, data_i, ready_i,
        output ready_o, valid_o, data_o, idx_o
    );

    modport master (
        output valid_i, data_i, ready_i,
        input  ready_o, valid_o, data_o, idx_o
    );

endinterface

// File: rtl/target_arbiter_rr_select.sv
// Combinational round-robin pick: first requester at or above ptr_i,
// wrapping to index 0, via a double-width masked priority encoder.
module rr_select
    import target_arbiter_pkg::*;
#(
    parameter int NumIn    = DefNumIn,
    parameter int NumInLog = idx_width(NumIn)
) (
    input  logic [NumIn-1:0]    req_i,
    input  logic [NumInLog-1:0] ptr_i,
    output logic [NumInLog-1:0] gnt_idx_o,
    output logic                gnt_vld_o
);

    // Lower half keeps only requests at or above the pointer; the upper half
    // is the full request vector, so the lowest set bit is the wrapped winner.
    logic [2*NumIn-1:0] req_dbl;

    for (genvar gi = 0; gi < NumIn; gi++) begin : g_dbl
        assign req_dbl[gi]         = req_i[gi] & (NumInLog'(gi) >= ptr_i);
        assign req_dbl[NumIn + gi] = req_i[gi];
    end

    always_comb begin
        gnt_idx_o = '0;
        for (int j = 2*NumIn - 1; j >= 0; j--) begin
            if (req_dbl[j]) begin
                gnt_idx_o = (j >= NumIn) ? NumInLog'(j - NumIn) : NumInLog'(j);
            end
        end
    end

    assign gnt_vld_o = |req_i;

endmodule

// File: rtl/target_arbiter.sv
// Target-side arbiter: fair round-robin pick among initiator requests into a
// single-entry registered output stage carrying payload and initiator index.
module target_arbiter
    import target_arbiter_pkg::*;
#(
    parameter int   NumIn     = DefNumIn,
    parameter int   DataWidth = DefDataWidth,
    parameter logic AxiVldRdy = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    target_arbiter_if.slave  bus
);

    localparam int NumInLog = idx_width(NumIn);

    if (NumIn < 1 || (AxiVldRdy !== 1'b0 && AxiVldRdy !== 1'b1)) begin : g_param_check
        $fatal(1, "target_arbiter: NumIn must be >= 1 and AxiVldRdy must be 0 or 1");
    end

    logic                 valid_q, valid_d;
    logic [DataWidth-1:0] data_q,  data_d;
    logic [NumInLog-1:0]  idx_q,   idx_d;
    logic [NumInLog-1:0]  rr_q,    rr_d;

    logic [NumInLog-1:0]  win_idx;
    logic                 win_vld;
    logic                 load;
    logic [NumIn-1:0]     ready_vec;

    rr_select #(
        .NumIn    (NumIn),
        .NumInLog (NumInLog)
    ) u_rr_select (
        .req_i     (bus.valid_i),
        .ptr_i     (rr_q),
        .gnt_idx_o (win_idx),
        .gnt_vld_o (win_vld)
    );

    // Load while empty or while the held entry drains this cycle.
    assign load = (~valid_q | bus.ready_i) & win_vld;

    for (genvar gi = 0; gi < NumIn; gi++) begin : g_ready
        assign ready_vec[gi] = load & (win_idx == NumInLog'(gi));
    end

    assign bus.ready_o = ready_vec;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        idx_d   = idx_q;
        rr_d    = rr_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = bus.data_i[win_idx];
            idx_d   = win_idx;
            rr_d    = (win_idx == NumInLog'(NumIn - 1)) ? '0 : win_idx + NumInLog'(1);
        end else if (bus.ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            idx_q   <= '0;
            rr_q    <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            idx_q   <= idx_d;
            rr_q    <= rr_d;
        end
    end

    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.idx_o   = idx_q;

endmodule
